// File: rtl/cave_input_conditioner.sv
// ---------------------------------------------------------------------------
// cave_input_conditioner
//
// Turns raw player inputs into the registered control vectors that feed the
// Cave core's Main joystick inputs. PS/2 key events are tracked as held keys,
// ORed with the HPS joystick bits, and registered. Each player's coin input is
// shaped into a single fixed-width pulse followed by a hold-off period.
//
// Ports:
//   clock       in   1   system clock (clk_sys)
//   reset       in   1   synchronous, active-high reset
//   ps2_key     in  11   [10] event toggle, [9] pressed, [8] extended (ignored),
//                        [7:0] scan code
//   joystick_0  in  11   player 1 HPS joystick: [0]R [1]L [2]D [3]U [4]B1
//                        [5]B2 [6]B3 [7]start [8]coin [9]pause
//   joystick_1  in  11   player 2, same layout as joystick_0
//   player1     out 10   [0]up [1]down [2]left [3]right [4]b1 [5]b2 [6]b3
//                        [7]start [8]coin [9]pause
//   player2     out 10   same layout as player1
//   service1    out  1   service 1 (key 9)
//   service2    out  1   service 2 (key 0)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// CaveCoinShaper
//
// Converts a level coin signal into one pulse of exactly COIN_CYCLES cycles,
// followed by a hold-off of COIN_CYCLES cycles during which new presses are
// discarded.
//
// Ports:
//   clock    in  1  system clock
//   reset    in  1  synchronous, active-high reset
//   rawCoin  in  1  combined (key OR joystick) coin level
//   pulse    out 1  shaped coin pulse, straight from the state register
// ---------------------------------------------------------------------------
module CaveCoinShaper #(
  parameter int unsigned COIN_CYCLES = 24'd3_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic rawCoin,
  output logic pulse
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(COIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } coinState_t;

  coinState_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             raw_q;

  // State, counter and the delayed coin level used for edge detection.
  // raw_q resets to 1 so a coin held through reset is not seen as a new press.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      raw_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      raw_q   <= rawCoin;
    end
  end

  // Next-state logic. Rising edges outside IDLE are simply ignored, so a
  // press during the pulse or hold-off is lost rather than queued.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (rawCoin && !raw_q) begin
          state_d = PULSE;
          count_d = RELOAD;
        end
      end
      PULSE: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          state_d = HOLDOFF;
          count_d = RELOAD;
        end
      end
      HOLDOFF: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign pulse = (state_q == PULSE);

endmodule

module cave_input_conditioner #(
  parameter int unsigned COIN_CYCLES = 24'd3_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [10:0] joystick_0,
  input  logic [10:0] joystick_1,
  output logic [9:0]  player1,
  output logic [9:0]  player2,
  output logic        service1,
  output logic        service2
);

  logic       toggle_q;
  logic [9:0] keyP1_q, keyP1_d;
  logic [8:0] keyP2_q, keyP2_d;
  logic       keySvc1_q, keySvc1_d;
  logic       keySvc2_q, keySvc2_d;

  logic [9:0] player1_q, player2_q;
  logic       service1_q, service2_q;

  logic       ps2Event;
  logic       ps2Pressed;
  logic [7:0] ps2Code;
  logic [9:0] p1Raw, p2Raw;
  logic       coin1Pulse, coin2Pulse;
  logic       unusedBits;

  assign ps2Event   = (ps2_key[10] != toggle_q);
  assign ps2Pressed = ps2_key[9];
  assign ps2Code    = ps2_key[7:0];

  // The extended-key flag and the top joystick bit carry nothing we need.
  assign unusedBits = ^{ps2_key[8], joystick_0[10], joystick_1[10]};

  // Key tracking: on a toggle change, the key whose scan code matches takes
  // the pressed flag. Unknown codes leave every key untouched.
  always_comb begin
    keyP1_d   = keyP1_q;
    keyP2_d   = keyP2_q;
    keySvc1_d = keySvc1_q;
    keySvc2_d = keySvc2_q;
    if (ps2Event) begin
      case (ps2Code)
        8'h75: keyP1_d[0] = ps2Pressed;
        8'h72: keyP1_d[1] = ps2Pressed;
        8'h6B: keyP1_d[2] = ps2Pressed;
        8'h74: keyP1_d[3] = ps2Pressed;
        8'h14: keyP1_d[4] = ps2Pressed;
        8'h11: keyP1_d[5] = ps2Pressed;
        8'h29: keyP1_d[6] = ps2Pressed;
        8'h16: keyP1_d[7] = ps2Pressed;
        8'h2E: keyP1_d[8] = ps2Pressed;
        8'h4D: keyP1_d[9] = ps2Pressed;
        8'h2D: keyP2_d[0] = ps2Pressed;
        8'h2B: keyP2_d[1] = ps2Pressed;
        8'h23: keyP2_d[2] = ps2Pressed;
        8'h34: keyP2_d[3] = ps2Pressed;
        8'h1C: keyP2_d[4] = ps2Pressed;
        8'h1B: keyP2_d[5] = ps2Pressed;
        8'h15: keyP2_d[6] = ps2Pressed;
        8'h1E: keyP2_d[7] = ps2Pressed;
        8'h36: keyP2_d[8] = ps2Pressed;
        8'h46: keySvc1_d  = ps2Pressed;
        8'h45: keySvc2_d  = ps2Pressed;
        default: ;
      endcase
    end
  end

  // The joystick word lists directions as R/L/D/U; the core wants U/D/L/R.
  // Player 2 has no pause key, so its pause bit comes from the joystick only.
  assign p1Raw = keyP1_q
               | {joystick_0[9:4], joystick_0[0], joystick_0[1], joystick_0[2], joystick_0[3]};
  assign p2Raw = {1'b0, keyP2_q}
               | {joystick_1[9:4], joystick_1[0], joystick_1[1], joystick_1[2], joystick_1[3]};

  // Key state and output registers. The toggle follows ps2_key[10] even in
  // reset so that leaving reset never looks like a fresh key event. The coin
  // bit of each output register stays 0; the shaper supplies it instead.
  always_ff @(posedge clock) begin
    if (reset) begin
      toggle_q   <= ps2_key[10];
      keyP1_q    <= '0;
      keyP2_q    <= '0;
      keySvc1_q  <= 1'b0;
      keySvc2_q  <= 1'b0;
      player1_q  <= '0;
      player2_q  <= '0;
      service1_q <= 1'b0;
      service2_q <= 1'b0;
    end else begin
      toggle_q   <= ps2_key[10];
      keyP1_q    <= keyP1_d;
      keyP2_q    <= keyP2_d;
      keySvc1_q  <= keySvc1_d;
      keySvc2_q  <= keySvc2_d;
      player1_q  <= {p1Raw[9], 1'b0, p1Raw[7:0]};
      player2_q  <= {p2Raw[9], 1'b0, p2Raw[7:0]};
      service1_q <= keySvc1_q;
      service2_q <= keySvc2_q;
    end
  end

  CaveCoinShaper #(
    .COIN_CYCLES(COIN_CYCLES),
    .CNT_W      (CNT_W)
  ) coinShaper1 (
    .clock  (clock),
    .reset  (reset),
    .rawCoin(p1Raw[8]),
    .pulse  (coin1Pulse)
  );

  CaveCoinShaper #(
    .COIN_CYCLES(COIN_CYCLES),
    .CNT_W      (CNT_W)
  ) coinShaper2 (
    .clock  (clock),
    .reset  (reset),
    .rawCoin(p2Raw[8]),
    .pulse  (coin2Pulse)
  );

  assign player1  = player1_q | {1'b0, coin1Pulse, 8'h00};
  assign player2  = player2_q | {1'b0, coin2Pulse, 8'h00};
  assign service1 = service1_q;
  assign service2 = service2_q;

endmodule
